alu_result_serializer: RTL
==========================

Name: alu_result_serializer

Overview:
- Downstream stage of the comparator/ALU result path.
- Captures a registered result word (CMP_OUT/ALU_OUT) when its valid flag is high.
- Splits the word into bytes, LSB first, and hands them one at a time to the UART transmitter through a valid/busy handshake.
- Reports completion, and reports results that arrive while a word is still being sent.

Parameters:
- OUT_WIDTH, 16: result word width. Must be a multiple of 8 and at least 8.
- NBYTES, OUT_WIDTH/8: number of bytes per word. Derived; never overridden.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  reset; synchronous and active-high.
- RES_DATA  input  OUT_WIDTH  result word from the ALU/comparator.
- RES_VLD  input  1  result valid; level or pulse; sampled every cycle.
- TX_BUSY  input  1  UART TX busy.
- TX_P_DATA  output  8  byte presented to the UART TX.
- TX_D_VLD  output  1  byte valid.
- SER_BUSY  output  1  high while a word is being sent (state != IDLE).
- SER_DONE  output  1  one-cycle pulse when the last byte of a word is accepted.
- SER_DROP  output  1  one-cycle pulse when a result is discarded.

Behaviour:
- Reset: synchronous, active-high; RST=1 at a rising edge overrides every other input.
  - State goes to IDLE.
  - TX_P_DATA=0, TX_D_VLD=0, SER_BUSY=0, SER_DONE=0, SER_DROP=0.
  - Shift register and byte counter cleared.
  - Reset mid-word aborts the word; partial bytes are not resent.
- All outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If RES_VLD=1: load shift register with RES_DATA, byte_cnt=0, go to SEND.
  - TX_D_VLD=1 and TX_P_DATA=RES_DATA[7:0] from the next cycle (1-cycle latency).
- SEND:
  - TX_D_VLD held at 1 and TX_P_DATA held stable until acceptance.
  - Acceptance: a cycle with TX_D_VLD=1 and TX_BUSY=0.
  - On acceptance with byte_cnt<NBYTES-1: shift register right by 8, byte_cnt+1, go to GAP, TX_D_VLD=0.
  - On acceptance with byte_cnt=NBYTES-1: go to IDLE, TX_D_VLD=0, SER_DONE=1 for one cycle.
  - While TX_BUSY=1: stay in SEND; no timeout.
- GAP:
  - Exactly one cycle with TX_D_VLD=0, so that a TX raising busy one cycle after acceptance is never double-loaded.
  - Next cycle: go to SEND; TX_P_DATA = next byte, TX_D_VLD=1.
- Byte order: byte i = RES_DATA[8i+7:8i] as captured, i=0..NBYTES-1.
- Captured word is frozen; RES_DATA changes during a word have no effect.
- SER_BUSY=1 in SEND and GAP, including the cycle SER_DONE is asserted's predecessor; SER_BUSY=0 in IDLE.
- Overlap: RES_VLD=1 in any cycle where state != IDLE gives SER_DROP=1 next cycle, and that result is discarded.
  - This includes the cycle in which the final byte is accepted; a new word is only captured from IDLE.
- Level-held RES_VLD: a RES_VLD held high through a whole word re-captures on the first IDLE cycle. This is intended; the upstream drops valid after one cycle.
- Minimum spacing between accepted words: NBYTES*2 cycles with TX_BUSY=0 throughout.
- Width rule: byte_cnt is clog2(NBYTES) bits, minimum 1; no wrap, because it resets on every capture.

Test Plan:
- Reset: RST=1 for 2 cycles with RES_VLD=1 -> all outputs 0, state IDLE; after release, nothing sent until a new RES_VLD.
- Basic word: OUT_WIDTH=16, RES_DATA=16'hA55A, 1-cycle RES_VLD, TX_BUSY=0 -> TX_P_DATA=8'h5A with VLD at cycle+1; VLD=0 at cycle+2; 8'hA5 with VLD at cycle+3; SER_DONE pulse at cycle+4; SER_BUSY high for cycles +1..+3.
- Backpressure: TX_BUSY=1 for 10 cycles after the first byte is accepted -> TX_P_DATA holds 8'hA5 with VLD=1 until TX_BUSY falls, then accepted; no byte lost or repeated.
- Drop: RES_VLD pulse with 16'h0003 during SEND of 16'h0002 -> SER_DROP one cycle; only bytes 02,00 transmitted.
- Final-byte collision: RES_VLD in the same cycle the last byte is accepted -> SER_DROP=1, SER_DONE=1, no new word started.
- Mid-word reset: RST=1 during GAP after byte 0 -> outputs 0 next cycle; a subsequent word 16'h1234 sends 34,12 cleanly; also rerun with OUT_WIDTH=32 (4 bytes, LSB first).

Source files
------------

// File: rtl/alu_result_serializer.sv
// ---------------------------------------------------------------------------
// alu_result_serializer
//
// Purpose:
//   Captures a result word from the comparator/ALU path and sends it to a
//   UART transmitter as a sequence of bytes, least-significant byte first.
//   Each byte is offered through a valid/busy handshake. After every accepted
//   byte except the last, the block inserts a one-cycle gap so that a
//   transmitter which raises busy one cycle late is never loaded twice.
//
// Ports:
//   CLK        in   system clock; all logic on the rising edge
//   RST        in   synchronous, active-high reset
//   RES_DATA   in   result word (OUT_WIDTH bits)
//   RES_VLD    in   result valid; sampled every cycle
//   TX_BUSY    in   UART transmitter busy
//   TX_P_DATA  out  byte offered to the transmitter
//   TX_D_VLD   out  byte valid
//   SER_BUSY   out  high while a word is in flight
//   SER_DONE   out  one-cycle pulse after the last byte is accepted
//   SER_DROP   out  one-cycle pulse when a result arrives while busy
//
// OUT_WIDTH must be a non-zero multiple of 8. All outputs are driven
// directly from flops.
// ---------------------------------------------------------------------------
module alu_result_serializer #(
    parameter int OUT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [OUT_WIDTH-1:0] RES_DATA,
    input  logic                 RES_VLD,
    input  logic                 TX_BUSY,
    output logic [7:0]           TX_P_DATA,
    output logic                 TX_D_VLD,
    output logic                 SER_BUSY,
    output logic                 SER_DONE,
    output logic                 SER_DROP
);

    localparam int NBYTES = OUT_WIDTH / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e                 state_q,     state_d;
    logic [OUT_WIDTH-1:0]   shift_q,     shift_d;
    logic [CNT_W-1:0]       byte_cnt_q,  byte_cnt_d;
    logic [7:0]             tx_data_q,   tx_data_d;
    logic                   tx_vld_q,    tx_vld_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;
    logic                   drop_q,      drop_d;

    logic                   accept_s;

    // A byte leaves the block on any cycle it is offered and the TX is free.
    assign accept_s = tx_vld_q & ~TX_BUSY;

    // Next-state and next-output computation for the serializer FSM.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        tx_data_d  = tx_data_q;
        tx_vld_d   = tx_vld_q;
        done_d     = 1'b0;
        // Any result seen outside IDLE is discarded, including the cycle in
        // which the final byte is accepted.
        drop_d     = RES_VLD & (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (RES_VLD) begin
                    shift_d    = RES_DATA;
                    byte_cnt_d = CNT_ZERO;
                    tx_data_d  = RES_DATA[7:0];
                    tx_vld_d   = 1'b1;
                    state_d    = ST_SEND;
                end else begin
                    tx_vld_d   = 1'b0;
                end
            end
            ST_SEND: begin
                if (accept_s) begin
                    tx_vld_d = 1'b0;
                    if (byte_cnt_q == CNT_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        shift_d    = shift_q >> 4'd8;
                        byte_cnt_d = byte_cnt_q + CNT_ONE;
                        state_d    = ST_GAP;
                    end
                end else begin
                    // Hold the current byte until the transmitter takes it.
                    tx_vld_d = 1'b1;
                end
            end
            ST_GAP: begin
                // The shift register already holds the next byte in its LSBs.
                tx_data_d = shift_q[7:0];
                tx_vld_d  = 1'b1;
                state_d   = ST_SEND;
            end
            default: begin
                tx_vld_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; synchronous reset has priority.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            byte_cnt_q <= CNT_ZERO;
            tx_data_q  <= 8'h00;
            tx_vld_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_vld_q   <= tx_vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign SER_BUSY  = busy_q;
    assign SER_DONE  = done_q;
    assign SER_DROP  = drop_q;

endmodule
